// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter and sequencer sharing one ALU between two requesters,
// trapping illegal modes and divide-by-zero before the ALU result reaches a requester.
module alu_share_ctrl #(
  parameter int W = 8,
  parameter logic [W-1:0] DIVZ_LO = 8'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [1:0]     req_cin,
  input  logic [5:0]     req_mode,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_lo,
  output logic [W-1:0]   rsp_hi,
  output logic           rsp_cout,
  output logic           rsp_err,
  output logic           busy,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_cin,
  output logic [2:0]     alu_mode,
  input  logic [W-1:0]   alu_ao,
  input  logic [W-1:0]   alu_bo,
  input  logic           alu_cout
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nxt;
  logic ptr, win, hs, trap;
  logic [W-1:0] a_w, b_w, a_r, b_r, lo_r, hi_r;
  logic [2:0] mode_w, mode_r;
  logic cin_w, cin_r, cout_r, id_r, err_r, div_zero;
  assign win = &req_valid ? ptr : req_valid[1];
  assign hs = rst_n && state == IDLE && |req_valid;
  assign req_ready = hs ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign a_w = win ? req_a[2*W-1:W] : req_a[W-1:0];
  assign b_w = win ? req_b[2*W-1:W] : req_b[W-1:0];
  assign cin_w = win ? req_cin[1] : req_cin[0];
  assign mode_w = win ? req_mode[5:3] : req_mode[2:0];
  assign div_zero = mode_w == 3'b101 && b_w == '0;
  assign trap = mode_w == 3'b111 || div_zero;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (hs ? (trap ? RESP : ISSUE) : IDLE) :
                state == ISSUE ? RESP :
                                 (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      cin_r <= 1'b0;
      mode_r <= '0;
      id_r <= 1'b0;
      lo_r <= '0;
      hi_r <= '0;
      cout_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (hs) begin
        a_r <= a_w;
        b_r <= b_w;
        cin_r <= cin_w;
        mode_r <= mode_w;
        id_r <= win;
        err_r <= trap;
        lo_r <= div_zero ? DIVZ_LO : '0;
        hi_r <= div_zero ? a_w : '0;
        cout_r <= 1'b0;
      end
      // only add/sub carry out, only mul/div have a meaningful high byte
      if (state == ISSUE) begin
        lo_r <= alu_ao;
        hi_r <= mode_r[2:1] == 2'b10 ? alu_bo : '0;
        cout_r <= mode_r[2:1] == 2'b00 && alu_cout;
        err_r <= 1'b0;
      end
      if (state == RESP && rsp_ready) ptr <= ~id_r;
    end
  end
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  assign rsp_id = id_r;
  assign rsp_lo = lo_r;
  assign rsp_hi = hi_r;
  assign rsp_cout = cout_r;
  assign rsp_err = err_r;
  assign alu_a = a_r;
  assign alu_b = b_r;
  assign alu_cin = cin_r;
  assign alu_mode = mode_r;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: random and directed stimulus against a transaction-level reference model.
module tb_alu_share_ctrl;
  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = 0, req_ready, req_cin = 0;
  logic [15:0] req_a = 0, req_b = 0;
  logic [5:0] req_mode = 0;
  logic rsp_valid, rsp_ready = 1, rsp_id, rsp_cout, rsp_err, busy, alu_cin, alu_cout;
  logic [7:0] rsp_lo, rsp_hi, alu_a, alu_b, alu_ao, alu_bo;
  logic [2:0] alu_mode;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_lo(rsp_lo),
    .rsp_hi(rsp_hi), .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
    .alu_ao(alu_ao), .alu_bo(alu_bo), .alu_cout(alu_cout)
  );
  // ALU stand-in {bo, ao, cout}; unused outputs carry junk so masking is exercised
  function automatic logic [16:0] alu_fn(logic [7:0] a, logic [7:0] b, logic cin, logic [2:0] m);
    logic [8:0] s;
    logic [15:0] p;
    case (m)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + 9'(cin); return {a ^ b, s[7:0], s[8]}; end
      3'd1: begin s = {1'b0, a} - {1'b0, b} - 9'(cin); return {8'h3C, s[7:0], s[8]}; end
      3'd2: return {8'h5A, a & b, 1'b1};
      3'd3: return {8'h5A, a | b, 1'b1};
      3'd4: begin p = a * b; return {p[15:8], p[7:0], 1'b1}; end
      3'd5: return b == 0 ? {8'hC3, 8'h77, 1'b1} : {a % b, a / b, 1'b1};
      3'd6: return {8'h5A, a ^ b, 1'b1};
      default: return {8'hA5, 8'h96, 1'b1};
    endcase
  endfunction
  always_comb {alu_bo, alu_ao, alu_cout} = alu_fn(alu_a, alu_b, alu_cin, alu_mode);
  // expected {lo, hi, cout, err}
  function automatic logic [17:0] ref_rsp(logic [7:0] a, logic [7:0] b, logic cin, logic [2:0] m);
    logic [16:0] r;
    r = alu_fn(a, b, cin, m);
    if (m == 3'd7) return {8'h00, 8'h00, 1'b0, 1'b1};
    if (m == 3'd5 && b == 0) return {8'hFF, a, 1'b0, 1'b1};
    if (m <= 3'd1) return {r[8:1], 8'h00, r[0], 1'b0};
    if (m == 3'd4 || m == 3'd5) return {r[8:1], r[16:9], 2'b00};
    return {r[8:1], 8'h00, 2'b00};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  bit m_busy = 0, m_ptr = 0, m_rst = 0, m_started = 0, m_id = 0, w;
  int cyc = 0, m_due = 0;
  logic [17:0] m_exp = 0;
  logic [19:0] m_op = 0;
  logic [1:0] exp_rdy;
  always @(negedge clk) begin
    w = &req_valid ? m_ptr : req_valid[1];
    exp_rdy = (rst_n && !m_busy && |req_valid) ? (w ? 2'b10 : 2'b01) : 2'b00;
    if (m_started) begin
      if (m_rst) check("rst_regs", {alu_a, alu_b, alu_cin, alu_mode, rsp_id, rsp_err}, '0);
      if (!m_busy) begin
        check("idle_out", {rsp_valid, busy}, 2'b00);
        check("grant", req_ready, exp_rdy);
      end else begin
        check("busy_out", {busy, req_ready}, 3'b100);
        check("rsp_valid", rsp_valid, cyc >= m_due);
        if (!m_exp[0] && cyc == m_due - 1)
          check("alu_drive", {alu_a, alu_b, alu_cin, alu_mode}, m_op);
        if (rsp_valid) check("rsp", {rsp_lo, rsp_hi, rsp_cout, rsp_err, rsp_id}, {m_exp, m_id});
      end
    end
    m_rst = 0;
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_rst = 1; m_started = 1;
    end else if (exp_rdy != 0) begin
      m_id = w;
      m_op = w ? {req_a[15:8], req_b[15:8], req_cin[1], req_mode[5:3]}
               : {req_a[7:0], req_b[7:0], req_cin[0], req_mode[2:0]};
      m_exp = ref_rsp(m_op[19:12], m_op[11:4], m_op[3], m_op[2:0]);
      m_due = cyc + (m_exp[0] ? 1 : 2);
      m_busy = 1;
    end else if (m_busy && rsp_ready && cyc >= m_due) begin
      m_busy = 0; m_ptr = ~m_id;
    end
    cyc++;
  end
  task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic cin, logic [2:0] m);
    req_a[i*8+:8] = a;
    req_b[i*8+:8] = b;
    req_cin[i] = cin;
    req_mode[i*3+:3] = m;
    req_valid[i] = 1'b1;
  endtask
  task automatic send(int i, logic [7:0] a, logic [7:0] b, logic cin, logic [2:0] m);
    set_req(i, a, b, cin, m);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    if (!req_ready[i]) check("grant_wait", req_ready[i], 1'b1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    idle(3);
    rst_n = 1;
    send(0, 8'hF0, 8'h20, 1'b1, 3'd0);
    idle(4);
    send(0, 8'h33, 8'h44, 1'b0, 3'd0);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(5);
    send(1, 8'h10, 8'h10, 1'b0, 3'd4);
    idle(4);
    send(0, 8'd17, 8'h00, 1'b0, 3'd5);
    idle(3);
    send(0, 8'h12, 8'h34, 1'b1, 3'd7);
    idle(3);
    set_req(0, 8'h01, 8'h02, 1'b0, 3'd0);
    set_req(1, 8'h03, 8'h04, 1'b1, 3'd1);
    for (int k = 0; k < 16; k++) begin
      idle(1);
      req_a = 16'($urandom);
      req_b = 16'($urandom) | 16'h0101;
      req_mode = {1'b0, 2'($urandom), 1'b0, 2'($urandom)};
    end
    req_valid = 0;
    idle(3);
    rsp_ready = 0;
    send(0, 8'h05, 8'h06, 1'b0, 3'd2);
    set_req(1, 8'h07, 8'h08, 1'b1, 3'd3);
    idle(7);
    rsp_ready = 1;
    send(1, 8'h07, 8'h08, 1'b1, 3'd3);
    idle(4);
    for (int k = 0; k < 500; k++) begin
      req_valid = 2'($urandom);
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) req_b[7:0] = 8'h00;
      if ($urandom_range(0, 3) == 0) req_b[15:8] = 8'h00;
      req_cin = 2'($urandom);
      req_mode = 6'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      idle(1);
    end
    rst_n = 1;
    req_valid = 0;
    rsp_ready = 1;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
